ex_mdu: RTL
===========

# ex_mdu

Parametrised iterative multiply/divide unit for the execute stage. It sits beside the single-cycle logic/shift datapath and takes over MULT, MULTU, DIV and DIVU, which cannot finish in one cycle. It uses a radix-2 shift-add or shift-subtract core and raises a stall request to the pipeline control while it works. The HI/LO result is held in registers for the HI/LO writeback path.

## Interface
Parameters:
- W, 32: operand width; must be even and at least 4.
- CNT_W, $clog2(W+1): width of the iteration counter; derived, never overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation code: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU.
- opa_i  in  W  multiplicand or dividend; sampled with start_i.
- opb_i  in  W  multiplier or divisor; sampled with start_i.
- annul_i  in  1  flush; aborts the operation in progress.
- stallreq_o  out  1  combinational stall request to pipeline control.
- valid_o  out  1  one-cycle pulse; hi_o and lo_o are final.
- hi_o  out  W  product upper half, or remainder.
- lo_o  out  W  product lower half, or quotient.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: hi_o = 0, lo_o = 0, valid_o = 0, counter = 0.
- IDLE with start_i=1 and annul_i=0:
  - Latch op_i and the operand magnitudes.
  - Signed ops take the absolute value (two's-complement negate when the MSB is 1).
  - Record the result sign flags.
- Transitions out of IDLE:
  - DIV or DIVU with opb_i = 0 goes directly to DONE.
  - Any other accepted op goes to CALC with counter = W.
- CALC: one iteration per cycle, counter decrements; at counter = 1 the next state is DONE.
  - Multiply: 2W-bit accumulator; each cycle add the multiplicand if the multiplier LSB is 1, then shift right by one.
  - Divide: restoring division, producing one quotient bit per cycle with a (W+1)-bit partial remainder.
- DONE: valid_o = 1; hi_o and lo_o are loaded from the signed-corrected result. Unconditionally returns to IDLE.
- Sign rules:
  - Product: negated if the operand signs differ.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the dividend's sign.
  - Unsigned ops skip all correction.
- Division by zero: lo = all ones; hi = opa_i unchanged.
- Signed MIN / -1: lo = MIN, hi = 0. This falls out of the magnitude path and needs no special case.
- hi_o and lo_o hold their value until the next DONE; an annulled op never updates them.
- annul_i:
  - In CALC or DONE: next state is IDLE, valid_o is suppressed, and the result registers are unchanged.
  - In IDLE: blocks acceptance of start_i.
- start_i outside IDLE is ignored. The pipeline holds the instruction, so start_i is expected to stay asserted.
- stallreq_o = (IDLE & start_i & ~annul_i) | CALC. It is low in DONE, which lets the stalled instruction retire that cycle.

## Timing
- Start sampled at the edge closing cycle 0 (state IDLE, start_i = 1).
- Normal op: CALC spans cycles 1..W; DONE and valid_o fall in cycle W+1. stallreq_o is high in cycles 0..W (W+1 cycles).
- Divide by zero: DONE in cycle 1; stallreq_o is high in cycle 0 only.
- Back-to-back: the next start is accepted at the earliest in cycle W+2 (IDLE), with no dead cycle beyond DONE.
- Asynchronous reset mid-CALC: the FSM returns to IDLE immediately, outputs go to their reset values, and stallreq_o drops combinationally.
- Annul and final-iteration edge in the same cycle: annul wins, no valid_o.

## Structure
- Shared package (the defines file):
  - MDU_MULT = 2'b00, MDU_MULTU = 2'b01, MDU_DIV = 2'b10, MDU_DIVU = 2'b11.
  - FSM state encodings.
  - The aluop-to-MDU op mapping used by the decoder.
- One sub-module: ex_mdu_cneg, a parametrised conditional two's-complement negate (in, en, out). It is instantiated for the operand abs step and for the result sign correction.

## Test plan
- MULT, W=32, opa=FFFFFFFD, opb=00000005 -> valid_o in cycle 33; hi=FFFFFFFF, lo=FFFFFFF1; stallreq_o high in cycles 0..32.
- MULTU, opa=FFFFFFFF, opb=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV with opa=FFFFFFF9, opb=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU with opa=00000007, opb=00000002 -> lo=00000003, hi=00000001.
- DIV opa=12345678, opb=0 -> valid_o in cycle 1, lo=FFFFFFFF, hi=12345678, stallreq_o high for exactly 1 cycle.
- DIV opa=80000000, opb=FFFFFFFF -> lo=80000000, hi=00000000.
- annul_i pulsed in cycle 10 of a MULT:
  - Required: IDLE next cycle, no valid_o, hi/lo unchanged.
  - Then DIVU 100/7 -> lo=0000000E, hi=00000002.
- Async reset at cycle 15 of a DIV -> stallreq_o low and outputs zero before the next edge; a following MULTU 3*4 gives lo=0000000C.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation codes, FSM encodings and the decoder's aluop-to-MDU mapping.
package ex_mdu_pkg;

    // Operation codes presented on op_i
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    // Control FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // Decoder aluop codes that are handed to the MDU
    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1B;

    // Decoded MDU request: whether the aluop belongs to the MDU, and which op
    typedef struct packed {
        logic    is_mdu;
        mdu_op_e op;
    } mdu_dec_t;

    // Map a decoder aluop onto an MDU request; non-MDU aluops give is_mdu = 0
    function automatic mdu_dec_t aluop_to_mdu(input logic [7:0] aluop);
        mdu_dec_t dec;
        dec.is_mdu = 1'b1;
        dec.op     = MDU_MULT;
        case (aluop)
            ALUOP_MULT:  dec.op = MDU_MULT;
            ALUOP_MULTU: dec.op = MDU_MULTU;
            ALUOP_DIV:   dec.op = MDU_DIV;
            ALUOP_DIVU:  dec.op = MDU_DIVU;
            default:     dec.is_mdu = 1'b0;
        endcase
        return dec;
    endfunction

    // True for the two divide operations
    function automatic logic mdu_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // True for the two operations that work on two's-complement operands
    function automatic logic mdu_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/ex_mdu_cneg.sv
// Conditional two's-complement negate: out = en ? -in : in.
// Used both to take operand magnitudes and to restore result signs.
import ex_mdu_pkg::*;

module ex_mdu_cneg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         en_i,
    output logic [W-1:0] out_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Invert-and-increment when enabled, pass through otherwise
    always_comb begin
        out_o = in_i;
        if (en_i) begin
            out_o = (~in_i) + ONE;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit
// per cycle, on operand magnitudes; signs are re-applied in DONE. The
// corrected result is shown on hi_o/lo_o during the DONE cycle and committed
// to the HI/LO holding registers on the edge that closes DONE, so an annul
// arriving in DONE leaves the held result untouched.
import ex_mdu_pkg::*;

module ex_mdu #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] opa_i,
    input  logic [W-1:0] opb_i,
    input  logic         annul_i,
    output logic         stallreq_o,
    output logic         valid_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Architectural state
    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;     // product, or {partial remainder, dividend/quotient}
    logic [W-1:0]     opd_q, opd_d;     // multiplicand or divisor magnitude
    logic             neg_q, neg_d;     // product/quotient must be negated
    logic             sgn_a_q, sgn_a_d; // remainder must be negated (negative dividend)
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;

    // Request decode
    mdu_op_e    op_in;
    logic       in_signed;
    logic       in_div;
    logic       sgn_a;
    logic       sgn_b;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;

    assign op_in     = mdu_op_e'(op_i);
    assign in_signed = mdu_is_signed(op_in);
    assign in_div    = mdu_is_div(op_in);
    assign sgn_a     = in_signed & opa_i[W-1];
    assign sgn_b     = in_signed & opb_i[W-1];

    ex_mdu_cneg #(.W(W)) u_abs_a (
        .in_i  (opa_i),
        .en_i  (sgn_a),
        .out_o (abs_a)
    );

    ex_mdu_cneg #(.W(W)) u_abs_b (
        .in_i  (opb_i),
        .en_i  (sgn_b),
        .out_o (abs_b)
    );

    // One multiply step: conditional add into the upper half, then shift right
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]};
        if (acc_q[0]) begin
            mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opd_q};
        end
        mul_next = {mul_sum, acc_q[W-1:1]};
    end

    // One restoring-divide step on a (W+1)-bit partial remainder
    logic [W:0]     div_rem_sh;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] div_next;

    always_comb begin
        div_rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge     = (div_rem_sh >= {1'b0, opd_q});
        // A successful subtract always leaves a remainder below the divisor,
        // so the low W bits of the difference are exact.
        div_diff   = div_rem_sh[W-1:0] - opd_q;
        if (div_ge) begin
            div_next = {div_diff, acc_q[W-2:0], 1'b1};
        end else begin
            div_next = {div_rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end
    end

    // Sign correction of the raw magnitude result
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;
    logic           op_is_div;

    ex_mdu_cneg #(.W(2*W)) u_fix_prod (
        .in_i  (acc_q),
        .en_i  (neg_q),
        .out_o (prod_fix)
    );

    ex_mdu_cneg #(.W(W)) u_fix_quo (
        .in_i  (acc_q[W-1:0]),
        .en_i  (neg_q),
        .out_o (quo_fix)
    );

    ex_mdu_cneg #(.W(W)) u_fix_rem (
        .in_i  (acc_q[2*W-1:W]),
        .en_i  (sgn_a_q),
        .out_o (rem_fix)
    );

    assign op_is_div = mdu_is_div(op_q);

    // Select product halves or {remainder, quotient} as the final result
    always_comb begin
        res_hi = prod_fix[2*W-1:W];
        res_lo = prod_fix[W-1:0];
        if (op_is_div) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        sgn_a_d = sgn_a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    op_d    = op_in;
                    neg_d   = sgn_a ^ sgn_b;
                    sgn_a_d = in_div & sgn_a;
                    if (in_div && (opb_i == '0)) begin
                        // Divide by zero: all-ones quotient, dividend as remainder, no correction
                        acc_d   = {opa_i, {W{1'b1}}};
                        neg_d   = 1'b0;
                        sgn_a_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_CALC;
                        if (in_div) begin
                            acc_d = {{W{1'b0}}, abs_a};
                            opd_d = abs_b;
                        end else begin
                            acc_d = {{W{1'b0}}, abs_b};
                            opd_d = abs_a;
                        end
                    end
                end
            end
            ST_CALC: begin
                if (annul_i) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = op_is_div ? div_next : mul_next;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!annul_i) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            neg_q   <= 1'b0;
            sgn_a_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            sgn_a_q <= sgn_a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Pipeline-facing outputs; stall is held low while reset is asserted
    always_comb begin
        stallreq_o = rst & (((state_q == ST_IDLE) & start_i & ~annul_i) | (state_q == ST_CALC));
        valid_o    = (state_q == ST_DONE) & ~annul_i;
        hi_o       = valid_o ? res_hi : hi_q;
        lo_o       = valid_o ? res_lo : lo_q;
    end

endmodule
